dense_seq_ctrl: RTL
===================

Name: dense_seq_ctrl

Overview:
- Sequencer for the dense-layer multiply datapath (weight ROM + 16x16 multiplier, product truncated to signed Q(1,6,9)).
- On start, walks all N_OUT neurons. For each neuron it streams N_IN (weight address, feature) pairs into the datapath and accumulates the returned products.
- Emits one saturated Q(1,6,9) result per neuron over a valid/ready handshake.
- Sits between the feature buffer (previous layer output) and the classifier/argmax stage.

Parameters:
- N_IN, 128, inputs per neuron.
- N_OUT, 11, neurons (modulation classes). N_IN*N_OUT must be <= 2^ADDR_W.
- ADDR_W, 11, weight address width.
- FEAT_AW, 7, feature buffer address width; must be >= clog2(N_IN).
- ROM_LAT, 2, cycles from addr_weights to weight at multiplier input.
- FEAT_LAT, 1, cycles from feat_addr to feat_data valid; must be <= ROM_LAT.
- MULT_LAT, 3, cycles from multiplier inputs to wx.
- ACC_W, 24, accumulator width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run the layer.
- busy  out  1  high from the cycle after an accepted start until the done pulse.
- done  out  1  one-cycle pulse after the last result is accepted.
- feat_addr  out  FEAT_AW  feature buffer read address.
- feat_data  in  16  feature, Q(1,6,9), valid FEAT_LAT cycles after feat_addr.
- addr_weights  out  ADDR_W  weight ROM address to the datapath.
- x  out  16  feature to the datapath multiplier.
- wx  in  16  product from the datapath, Q(1,6,9).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  16  neuron result, Q(1,6,9).
- out_idx  out  4  neuron index of out_data.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulator 0, tag pipeline cleared.
- Reset mid-run aborts the run. Products still in flight are discarded, and no done pulse is issued.
- FSM states:
  - IDLE: start=1 -> ISSUE with o=0, i=0, acc cleared. start is ignored in every other state.
  - ISSUE: one pair per cycle, for i = 0..N_IN-1:
    - addr_weights = o*N_IN + i; feat_addr = i.
    - Push a tag bit (1) plus a last flag (i==N_IN-1) into a shift register of depth ROM_LAT+MULT_LAT.
    - After i = N_IN-1 -> DRAIN.
  - DRAIN: wait until the last-flag tag emerges and has been accumulated -> OUT.
  - OUT:
    - out_valid=1, out_idx=o, out_data = saturate(acc).
    - On out_valid&&out_ready: if o==N_OUT-1 -> DONE, else o++, acc=0 -> ISSUE.
    - out_valid, out_data and out_idx are held stable until accepted.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Alignment:
  - x = feat_data delayed by ROM_LAT-FEAT_LAT register stages (0 means combinational pass-through).
  - x therefore meets the weight read for the same address at the multiplier.
  - x = 0 in cycles without an issued pair.
- Accumulate: in each cycle the tag pipe output is 1, acc += sign_extend(wx, ACC_W). Non-tagged wx is ignored.
- Saturation at output:
  - acc > 32767 -> 16'h7FFF.
  - acc < -32768 -> 16'h8000.
  - Otherwise acc[15:0].
  - The accumulator itself must not wrap for N_IN <= 256.
- Latency:
  - First result is valid ROM_LAT+MULT_LAT+N_IN+1 cycles after start (defaults: 134).
  - Each later result is valid the same number of cycles after the previous one is accepted.
- Back-to-back: out_ready held 1 gives no bubble beyond DRAIN. The next neuron's ISSUE begins the cycle after acceptance.

Optional Feature:
- DENSE_RELU_EN defined: out_data = 0 whenever the saturated result is negative. Applied after saturation; out_idx is unaffected.
- Not defined: signed saturated result is passed through (logits for argmax).

Test Plan:
- N_IN=4, N_OUT=2, features {1,2,3,4}, datapath model returns wx = addr+1 -> out_data 10 (idx 0), then 26 (idx 1); done pulses once; busy drops with done.
- Alignment: ROM_LAT=2, FEAT_LAT=1, MULT_LAT=3, ramp features -> x at cycle t+2 equals feature for addr_weights issued at cycle t, for every i.
- Saturation: all wx = 16'h7FFF, N_IN=4 -> out_data 16'h7FFF; all wx = 16'h8000 -> 16'h8000.
- Backpressure: out_ready low 20 cycles on neuron 0 -> out_valid/out_data/out_idx stable, no ISSUE activity; release -> neuron 1 completes correctly.
- Reset mid-ISSUE of neuron 1, then start -> outputs 0 on reset, fresh run gives correct results from idx 0; stray wx from aborted run not accumulated.
- DENSE_RELU_EN: sum -5 -> out_data 0; without macro -> 16'hFFFB.

Source files
------------

// File: rtl/dense_seq_ctrl_if.sv
// dense_seq_ctrl_if: result stream from the dense-layer sequencer to the
// classifier/argmax stage. One neuron result per valid/ready transfer.
interface dense_seq_ctrl_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_idx;

  modport master (output out_valid, output out_data, output out_idx, input out_ready);
  modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: sequencer for the dense-layer multiply datapath.
// For every neuron it streams N_IN (weight address, feature) pairs into the
// external weight ROM + 16x16 multiplier, accumulates the returned Q(1,6,9)
// products and emits one saturated Q(1,6,9) result over a valid/ready stream.
// A tag shift register of depth ROM_LAT+MULT_LAT marks which returning
// products belong to issued pairs, so stray datapath output is never summed.
// Build option: define DENSE_RELU_EN to clamp negative results to zero;
// without it the signed saturated logit is passed through.
module dense_seq_ctrl #(
  parameter int N_IN     = 128,
  parameter int N_OUT    = 11,
  parameter int ADDR_W   = 11,
  parameter int FEAT_AW  = 7,
  parameter int ROM_LAT  = 2,
  parameter int FEAT_LAT = 1,
  parameter int MULT_LAT = 3,
  parameter int ACC_W    = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [FEAT_AW-1:0]  feat_addr,
  input  logic [15:0]         feat_data,
  output logic [ADDR_W-1:0]   addr_weights,
  output logic [15:0]         x,
  input  logic [15:0]         wx,
  dense_seq_ctrl_if.master    res
);

  localparam int TAG_D = ROM_LAT + MULT_LAT;
  localparam int X_D   = ROM_LAT - FEAT_LAT;
  localparam logic [FEAT_AW-1:0] LAST_I = FEAT_AW'(N_IN - 1);
  localparam logic [3:0]         LAST_O = 4'(N_OUT - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [3:0]                o_q, o_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      issue_q, issue_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [FEAT_AW-1:0]        feat_addr_q, feat_addr_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic                      out_valid_q, out_valid_d;
  logic [15:0]               out_data_q, out_data_d;
  logic [3:0]                out_idx_q, out_idx_d;
  logic [TAG_D-1:0]          tag_vld_q, tag_vld_d;
  logic [TAG_D-1:0]          tag_last_q, tag_last_d;

  logic                      tag_out_s;
  logic                      tag_last_out_s;
  logic signed [ACC_W-1:0]   wx_ext_s;
  logic signed [ACC_W-1:0]   acc_sum_s;
  logic [15:0]               x_raw_s;
  logic                      x_vld_s;

  // Clamp the accumulator to Q(1,6,9) range, optionally rectified.
  function automatic logic [15:0] result_fmt(input logic signed [ACC_W-1:0] v);
    logic [15:0] r;
    if (v > ACC_MAX) begin
      r = 16'h7FFF;
    end else if (v < ACC_MIN) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
`ifdef DENSE_RELU_EN
    if (r[15]) begin
      r = 16'h0000;
    end else begin
      r = r;
    end
`endif
    return r;
  endfunction

  assign tag_out_s      = tag_vld_q[TAG_D-1];
  assign tag_last_out_s = tag_last_q[TAG_D-1];
  assign wx_ext_s       = ACC_W'($signed(wx));
  assign acc_sum_s      = acc_q + wx_ext_s;

  // Tag pipe: one entry per issued pair, emerging when its product arrives.
  always_comb begin
    tag_vld_d     = tag_vld_q;
    tag_last_d    = tag_last_q;
    tag_vld_d[0]  = issue_q;
    tag_last_d[0] = issue_q && (feat_addr_q == LAST_I);
    for (int k = 1; k < TAG_D; k++) begin
      tag_vld_d[k]  = tag_vld_q[k-1];
      tag_last_d[k] = tag_last_q[k-1];
    end
  end

  // Tag pipe registers; reset drops every product still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q  <= '0;
      tag_last_q <= '0;
    end else begin
      tag_vld_q  <= tag_vld_d;
      tag_last_q <= tag_last_d;
    end
  end

  // Feature alignment: delay feat_data so it meets the weight at the multiplier.
  generate
    if (X_D == 0) begin : g_x_comb
      assign x_raw_s = feat_data;
    end else begin : g_x_pipe
      logic [15:0] xpipe_q [X_D];
      logic [15:0] xpipe_d [X_D];

      // Shift the returned feature by the ROM/feature-buffer latency gap.
      always_comb begin
        xpipe_d[0] = feat_data;
        for (int k = 1; k < X_D; k++) begin
          xpipe_d[k] = xpipe_q[k-1];
        end
      end

      // Feature delay registers.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < X_D; k++) begin
            xpipe_q[k] <= 16'h0000;
          end
        end else begin
          for (int k = 0; k < X_D; k++) begin
            xpipe_q[k] <= xpipe_d[k];
          end
        end
      end

      assign x_raw_s = xpipe_q[X_D-1];
    end

    if (ROM_LAT == 0) begin : g_xv_now
      assign x_vld_s = issue_q;
    end else begin : g_xv_dly
      assign x_vld_s = tag_vld_q[ROM_LAT-1];
    end
  endgenerate

  // Multiplier sees zero whenever no pair was issued for this slot.
  assign x = x_vld_s ? x_raw_s : 16'h0000;

  // Sequencer: next state, counters, accumulator and next-cycle outputs.
  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    acc_d       = acc_q;
    issue_d     = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    feat_addr_d = feat_addr_q;
    addr_d      = addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;

    if (tag_out_s) begin
      acc_d = acc_sum_s;
    end else begin
      acc_d = acc_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ISSUE;
          o_d         = 4'd0;
          acc_d       = '0;
          issue_d     = 1'b1;
          busy_d      = 1'b1;
          feat_addr_d = '0;
          addr_d      = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (feat_addr_q == LAST_I) begin
          state_d = S_DRAIN;
        end else begin
          state_d     = S_ISSUE;
          issue_d     = 1'b1;
          feat_addr_d = feat_addr_q + FEAT_AW'(1);
          addr_d      = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        // The last product is summed in this same cycle, so format acc_sum_s.
        if (tag_out_s && tag_last_out_s) begin
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_data_d  = result_fmt(acc_sum_s);
          out_idx_d   = o_q;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (res.out_ready) begin
          out_valid_d = 1'b0;
          out_data_d  = 16'h0000;
          out_idx_d   = 4'd0;
          if (o_q == LAST_O) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            // Next neuron's weights follow directly after this one's.
            state_d     = S_ISSUE;
            o_d         = o_q + 4'd1;
            acc_d       = '0;
            issue_d     = 1'b1;
            feat_addr_d = '0;
            addr_d      = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      o_q         <= 4'd0;
      acc_q       <= '0;
      issue_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      feat_addr_q <= '0;
      addr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_idx_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      issue_q     <= issue_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      feat_addr_q <= feat_addr_d;
      addr_q      <= addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign feat_addr     = feat_addr_q;
  assign addr_weights  = addr_q;
  assign res.out_valid = out_valid_q;
  assign res.out_data  = out_data_q;
  assign res.out_idx   = out_idx_q;

endmodule
